// File: rtl/branch_resolve_unit.sv
// Registered branch/JAL/JALR resolver: evaluates the condition, target and next PC,
// checks them against the front-end prediction and keeps saturating retire statistics.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_ctrl,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_next_pc,
  output logic             out_mispredict,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_branch, is_jal, is_jalr, is_ctrl;
  logic [XLEN-1:0] imm_b, imm_j, imm_i;
  logic [XLEN-1:0] pc_plus4, jalr_sum;
  logic [XLEN:0]   diff;
  logic            eq, lt, ltu, cond;
  logic            taken, mispredict;
  logic [XLEN-1:0] target, next_pc;
  logic            accept, retire;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  assign is_branch = (opcode == OP_BRANCH) && (funct3 != 3'd2) && (funct3 != 3'd3);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR) && (funct3 == 3'd0);
  assign is_ctrl   = is_branch || is_jal || is_jalr;

  assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

  // One zero-extended subtractor serves equality, unsigned and signed compares.
  assign diff = {1'b0, in_rs1} - {1'b0, in_rs2};
  assign eq   = ~|diff[XLEN-1:0];
  assign ltu  = diff[XLEN];
  assign lt   = (in_rs1[XLEN-1] != in_rs2[XLEN-1]) ? in_rs1[XLEN-1] : diff[XLEN-1];

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'd0:    cond = eq;
      3'd1:    cond = !eq;
      3'd4:    cond = lt;
      3'd5:    cond = !lt;
      3'd6:    cond = ltu;
      3'd7:    cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  assign pc_plus4 = in_pc + XLEN'(4);
  assign jalr_sum = in_rs1 + imm_i;

  always_comb begin
    target = pc_plus4;
    taken  = 1'b0;
    if (is_branch) begin
      target = in_pc + imm_b;
      taken  = cond;
    end else if (is_jal) begin
      target = in_pc + imm_j;
      taken  = 1'b1;
    end else if (is_jalr) begin
      target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
      taken  = 1'b1;
    end
  end

  assign next_pc = taken ? target : pc_plus4;

  // A predicted-taken non-control instruction is always a redirect.
  assign mispredict = is_ctrl ? ((taken != in_pred_taken) ||
                                 (taken && in_pred_taken && (in_pred_target != target)))
                              : in_pred_taken;

  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign retire   = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      out_is_ctrl      <= 1'b0;
      out_taken        <= 1'b0;
      out_target       <= '0;
      out_next_pc      <= '0;
      out_mispredict   <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid      <= 1'b1;
        out_is_ctrl    <= is_ctrl;
        out_taken      <= taken;
        out_target     <= target;
        out_next_pc    <= next_pc;
        out_mispredict <= mispredict;
      end else if (retire) begin
        out_valid <= 1'b0;
      end

      if (retire) begin
        if (out_is_ctrl && (stat_branches != '1))
          stat_branches <= stat_branches + CNT_W'(1);
        if (out_mispredict && (stat_mispredicts != '1))
          stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, handshake corner sequences,
// randomized traffic against a behavioural model, plus CNT_W=2 and XLEN=64 instances.
module tb_branch_resolve_unit;

  typedef struct {
    logic        ctrl;
    logic        taken;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        misp;
  } res_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pt;
    logic [31:0] ptgt;
    res_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2, in_pred_target;
  logic        in_pred_taken;
  logic        out_valid, out_is_ctrl, out_taken, out_mispredict;
  logic [31:0] out_target, out_next_pc;
  logic [15:0] stat_branches, stat_mispredicts;

  logic        s_in_ready, s_out_valid, s_out_is_ctrl, s_out_taken, s_out_mispredict;
  logic [31:0] s_out_target, s_out_next_pc;
  logic [1:0]  s_stat_br, s_stat_mp;

  logic        w_in_valid, w_in_ready, w_pt, w_out_valid, w_out_ready;
  logic        w_ctrl, w_taken, w_misp;
  logic [31:0] w_instr;
  logic [63:0] w_pc, w_rs1, w_rs2, w_ptgt, w_target, w_next;
  logic [15:0] w_stat_br, w_stat_mp;

  int   checks   = 0;
  int   failures = 0;
  logic m_valid;
  res_t m_res;
  res_t cur_exp;
  int   cnt_br, cnt_mp;
  vec_t vt[16];

  branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_ctrl(out_is_ctrl),
    .out_taken(out_taken), .out_target(out_target), .out_next_pc(out_next_pc),
    .out_mispredict(out_mispredict), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts));

  branch_resolve_unit #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_is_ctrl(s_out_is_ctrl),
    .out_taken(s_out_taken), .out_target(s_out_target), .out_next_pc(s_out_next_pc),
    .out_mispredict(s_out_mispredict), .stat_branches(s_stat_br),
    .stat_mispredicts(s_stat_mp));

  branch_resolve_unit #(.XLEN(64), .CNT_W(16)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_instr(w_instr), .in_pc(w_pc), .in_rs1(w_rs1), .in_rs2(w_rs2),
    .in_pred_taken(w_pt), .in_pred_target(w_ptgt), .flush(1'b0),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_is_ctrl(w_ctrl),
    .out_taken(w_taken), .out_target(w_target), .out_next_pc(w_next),
    .out_mispredict(w_misp), .stat_branches(w_stat_br),
    .stat_mispredicts(w_stat_mp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] satv(input int c, input int mx);
    return (c > mx) ? 64'(mx) : 64'(c);
  endfunction

  // Behavioural resolution from the ISA rules using native signed/unsigned compares.
  function automatic res_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic pt, input logic [31:0] ptgt);
    res_t r;
    logic [6:0] op;
    logic [2:0] f3;
    logic signed [12:0] bs;
    logic signed [20:0] js;
    logic signed [11:0] ii;
    int bimm, jimm, iimm;
    op = ins[6:0];
    f3 = ins[14:12];
    bs = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    js = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    ii = ins[31:20];
    bimm = bs; jimm = js; iimm = ii;
    r = '{default: '0};
    r.target = pc + 32'd4;
    if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
      r.ctrl   = 1'b1;
      r.target = pc + bimm;
      case (f3)
        3'd0: r.taken = (a == b);
        3'd1: r.taken = (a != b);
        3'd4: r.taken = ($signed(a) <  $signed(b));
        3'd5: r.taken = ($signed(a) >= $signed(b));
        3'd6: r.taken = (a <  b);
        default: r.taken = (a >= b);
      endcase
    end else if (op == 7'h6F) begin
      r.ctrl = 1'b1; r.taken = 1'b1;
      r.target = pc + jimm;
    end else if (op == 7'h67 && f3 == 3'd0) begin
      r.ctrl = 1'b1; r.taken = 1'b1;
      r.target = (a + iimm) & ~32'd1;
    end
    r.next_pc = r.taken ? r.target : pc + 32'd4;
    r.misp = r.ctrl ? ((r.taken != pt) || (r.taken && pt && ptgt != r.target)) : pt;
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, pc, a, b, input logic pt,
                              input logic [31:0] ptgt, input logic c, t,
                              input logic [31:0] tg, np, input logic m);
    vec_t v;
    v.instr = ins; v.pc = pc; v.rs1 = a; v.rs2 = b; v.pt = pt; v.ptgt = ptgt;
    v.exp.ctrl = c; v.exp.taken = t; v.exp.target = tg; v.exp.next_pc = np; v.exp.misp = m;
    return v;
  endfunction

  task automatic set_beat(input vec_t v);
    in_instr = v.instr; in_pc = v.pc; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_pred_taken = v.pt; in_pred_target = v.ptgt;
    cur_exp = v.exp;
  endtask

  // One clock: checks in_ready before the edge, advances the handshake model, checks outputs.
  task automatic tick();
    logic exp_rdy, fire, acc;
    #1;
    exp_rdy = rst_n && (!m_valid || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    fire = rst_n && m_valid && out_ready && !flush;
    acc  = exp_rdy && in_valid && !flush;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_res = '{default: '0}; cnt_br = 0; cnt_mp = 0;
    end else begin
      if (fire) begin
        cnt_br += int'(m_res.ctrl);
        cnt_mp += int'(m_res.misp);
      end
      if (flush)      m_valid = 1'b0;
      else if (acc)   begin m_valid = 1'b1; m_res = cur_exp; end
      else if (fire)  m_valid = 1'b0;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_is_ctrl", out_is_ctrl, m_res.ctrl);
    chk("out_taken", out_taken, m_res.taken);
    chk("out_target", out_target, m_res.target);
    chk("out_next_pc", out_next_pc, m_res.next_pc);
    chk("out_mispredict", out_mispredict, m_res.misp);
    chk("stat_branches", stat_branches, satv(cnt_br, 65535));
    chk("stat_mispredicts", stat_mispredicts, satv(cnt_mp, 65535));
    chk("sat_stat_branches", s_stat_br, satv(cnt_br, 3));
    chk("sat_stat_mispredicts", s_stat_mp, satv(cnt_mp, 3));
  endtask

  task automatic wide_vec(input logic [31:0] ins, input logic [63:0] pc, a, b,
                          input logic pt, input logic [63:0] ptgt, input logic c, t,
                          input logic [63:0] tg, np, input logic m);
    w_instr = ins; w_pc = pc; w_rs1 = a; w_rs2 = b; w_pt = pt; w_ptgt = ptgt;
    w_in_valid = 1'b1; w_out_ready = 1'b1;
    tick();
    chk("w_out_valid", w_out_valid, 1'b1);
    chk("w_is_ctrl", w_ctrl, c);
    chk("w_taken", w_taken, t);
    chk("w_target", w_target, tg);
    chk("w_next_pc", w_next, np);
    chk("w_mispredict", w_misp, m);
  endtask

  initial begin
    logic [31:0] base, ins, pc, a, b, ptgt;
    logic        pt;
    res_t        tmp;

    vt[0]  = mk(32'h00B50463, 32'h100, 32'd5, 32'd5, 1'b0, 32'h0,          1, 1, 32'h108, 32'h108, 1);
    vt[1]  = mk(32'h00B54463, 32'h200, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h208, 1, 1, 32'h208, 32'h208, 0);
    vt[2]  = mk(32'h00B56463, 32'h200, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0,   1, 0, 32'h208, 32'h204, 0);
    vt[3]  = mk(32'h00B55463, 32'h300, 32'h80000000, 32'h80000000, 1'b1, 32'h30C, 1, 1, 32'h308, 32'h308, 1);
    vt[4]  = mk(32'h00B57463, 32'h400, 32'd1, 32'hFFFFFFFF, 1'b1, 32'h408, 1, 0, 32'h408, 32'h404, 1);
    vt[5]  = mk(32'h00B51463, 32'h500, 32'd3, 32'd3, 1'b0, 32'h0,          1, 0, 32'h508, 32'h504, 0);
    vt[6]  = mk(32'h00B51463, 32'h500, 32'd3, 32'd4, 1'b1, 32'h508,        1, 1, 32'h508, 32'h508, 0);
    vt[7]  = mk(32'hFEB50EE3, 32'h1000, 32'd7, 32'd7, 1'b1, 32'hFFC,       1, 1, 32'hFFC, 32'hFFC, 0);
    vt[8]  = mk(32'h010000EF, 32'h800, 32'd0, 32'd0, 1'b0, 32'h0,          1, 1, 32'h810, 32'h810, 1);
    vt[9]  = mk(32'h004500E7, 32'h3000, 32'h2003, 32'd0, 1'b1, 32'h2006,   1, 1, 32'h2006, 32'h2006, 0);
    vt[10] = mk(32'h004500E7, 32'h3000, 32'h2003, 32'd0, 1'b1, 32'h2008,   1, 1, 32'h2006, 32'h2006, 1);
    vt[11] = mk(32'h004510E7, 32'h3000, 32'h2003, 32'd0, 1'b1, 32'h3004,   0, 0, 32'h3004, 32'h3004, 1);
    vt[12] = mk(32'h00B52463, 32'h600, 32'd1, 32'd1, 1'b0, 32'h0,          0, 0, 32'h604, 32'h604, 0);
    vt[13] = mk(32'h00B50533, 32'h700, 32'd1, 32'd2, 1'b1, 32'h704,        0, 0, 32'h704, 32'h704, 1);
    vt[14] = mk(32'hFF9FF06F, 32'h4, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFC,     1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0);
    vt[15] = mk(32'h00B54463, 32'h200, 32'd5, 32'd3, 1'b0, 32'h0,          1, 0, 32'h208, 32'h204, 0);

    m_valid = 1'b0; m_res = '{default: '0}; cnt_br = 0; cnt_mp = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    set_beat(vt[0]);
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_instr = '0; w_pc = '0;
    w_rs1 = '0; w_rs2 = '0; w_pt = 1'b0; w_ptgt = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed table, one beat per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_beat(vt[i]);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: result held three cycles, then one retire plus same-cycle accept
    in_valid = 1'b1; set_beat(vt[8]); tick();
    out_ready = 1'b0; set_beat(vt[0]);
    repeat (3) tick();
    out_ready = 1'b1; tick();
    in_valid = 1'b0; tick();

    // Flush with a live result and an incoming beat
    in_valid = 1'b1; set_beat(vt[9]); tick();
    set_beat(vt[10]); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; tick();
    chk("flush_no_resurrect", out_valid, 1'b0);

    // Reset while a result is held
    in_valid = 1'b1; set_beat(vt[3]); tick();
    in_valid = 1'b0; out_ready = 1'b0; tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; out_ready = 1'b1; tick();

    // Five retired branches saturate a 2-bit counter at 3
    in_valid = 1'b1; set_beat(vt[8]);
    repeat (5) tick();
    in_valid = 1'b0; tick();
    chk("sat_after_five", s_stat_br, 2'd3);

    // XLEN=64 instance
    wide_vec(32'h00B50533, 64'hFFFFFFFFFFFFFFFC, 64'd1, 64'd2, 1'b0, 64'd0,
             0, 0, 64'd0, 64'd0, 0);
    wide_vec(32'h00B54463, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 64'd0,
             1, 1, 64'h1008, 64'h1008, 1);
    wide_vec(32'h00B56463, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 64'd0,
             1, 0, 64'h1008, 64'h1004, 0);
    wide_vec(32'h004500E7, 64'h40, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 64'd2,
             1, 1, 64'd2, 64'd2, 0);
    w_in_valid = 1'b0;

    // Randomized traffic with flush, backpressure and occasional reset
    for (int n = 0; n < 600; n++) begin
      base = $urandom;
      case ($urandom_range(0, 5))
        0, 1: ins = {base[31:7], 7'h63};
        2:    ins = {base[31:7], 7'h6F};
        3:    ins = {base[31:15], 3'b000, base[11:7], 7'h67};
        4:    ins = {base[31:7], 7'h67};
        default: ins = base;
      endcase
      pc = $urandom;
      pc[1:0] = 2'b00;
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      pt = 1'($urandom_range(0, 1));
      tmp = ref_model(ins, pc, a, b, pt, 32'd0);
      ptgt = ($urandom_range(0, 1) == 1) ? tmp.target : $urandom;
      in_instr = ins; in_pc = pc; in_rs1 = a; in_rs2 = b;
      in_pred_taken = pt; in_pred_target = ptgt;
      cur_exp = ref_model(ins, pc, a, b, pt, ptgt);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
